// File: rtl/phy_tx_serial_pkg.sv
// Shared symbols for the serial transmit PHY: control bytes, FSM encoding and lane helpers.
// The receive PHY relies on the same COM/IDL values and state encoding.
package phy_tx_serial_pkg;

  localparam logic [7:0] PHY_COM = 8'hBC;
  localparam logic [7:0] PHY_IDL = 8'h7C;

  localparam int NUM_LANES = 4;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/phy_tx_serial_piso8.sv
// 8-bit parallel-in/serial-out register, MSB first, zero-filled on shift.
// Reset preloads COM so the line idles on a sync byte while reset is held.
module piso8
  import phy_tx_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       q_msb,
  output logic [7:0] q
);

  logic [7:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= PHY_COM;
    end else if (load) begin
      shreg <= din;
    end else begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign q   = shreg;
  assign q_msb = shreg[7];

endmodule

// File: rtl/phy_tx_serial.sv
// Serial transmit PHY: sends SYNC_COUNT COM bytes after reset, then round-robins four
// 8-bit lanes MSB first, substituting IDL for any lane that is not valid at its load cycle.
module phy_tx_serial
  import phy_tx_serial_pkg::*;
#(
  parameter int SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  output logic [3:0] lane_ack,
  output logic       data_out,
  output logic       active,
  output logic [7:0] byte_mon
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);

  tx_state_t  state;
  logic [2:0] bit_cnt;
  logic [1:0] lane;
  logic [7:0] sync_cnt;

  logic [7:0] lane_data [NUM_LANES];
  logic [NUM_LANES-1:0] lane_valid;

  logic       load;
  logic       sync_last;
  logic       send_lane;
  logic [1:0] sel_lane;
  logic [7:0] next_byte;
  logic [3:0] ack_next;
  logic [7:0] shreg;

  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;
  assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

  assign load      = (bit_cnt == 3'd7);
  assign sync_last = (sync_cnt == SYNC_LAST);
  // The final sync load already carries lane 0, so the lane path opens one byte early.
  assign send_lane = (state == RUN) || sync_last;
  assign sel_lane  = (state == RUN) ? lane : 2'd0;

  always_comb begin
    next_byte = PHY_COM;
    ack_next  = '0;
    if (send_lane) begin
      if (lane_valid[sel_lane]) begin
        next_byte = lane_data[sel_lane];
        ack_next  = lane_onehot(sel_lane);
      end else begin
        next_byte = PHY_IDL;
      end
    end
  end

  always_ff @(posedge clk_32f or posedge default_values) begin
    if (default_values) begin
      state    <= SYNC;
      bit_cnt  <= 3'd0;
      lane     <= 2'd0;
      sync_cnt <= 8'd0;
      active   <= 1'b0;
      lane_ack <= 4'd0;
      byte_mon <= PHY_COM;
    end else begin
      bit_cnt  <= bit_cnt + 3'd1;
      lane_ack <= load ? ack_next : 4'd0;
      if (load) begin
        byte_mon <= next_byte;
        case (state)
          SYNC: begin
            if (sync_last) begin
              state  <= RUN;
              active <= 1'b1;
              lane   <= 2'd1;
            end else begin
              sync_cnt <= sync_cnt + 8'd1;
            end
          end
          RUN: begin
            lane <= lane + 2'd1;
          end
          default: begin
            state <= SYNC;
          end
        endcase
      end
    end
  end

  piso8 u_piso8 (
    .clk   (clk_32f),
    .rst   (default_values),
    .load  (load),
    .din   (next_byte),
    .q_msb (data_out),
    .q     (shreg)
  );

  logic unused_shreg;
  assign unused_shreg = ^shreg;

endmodule
